// File: rtl/msp430_pkg.sv
// Shared constants for the MSP430 instruction sequencer: address-source codes,
// FSM state encoding, opcode fields, addressing modes and register indices.
package msp430_pkg;

  localparam int unsigned IR_W    = 16;
  localparam int unsigned MAB_W   = 3;
  localparam int unsigned STATE_W = 4;

  // Memory address bus source select
  localparam logic [MAB_W-1:0] MAB_PC   = 3'd0;
  localparam logic [MAB_W-1:0] MAB_SP   = 3'd1;
  localparam logic [MAB_W-1:0] MAB_CALC = 3'd2;

  // Sequencer states; encoding order is visible on the debug port
  typedef enum logic [STATE_W-1:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_SRC_EXT = 4'd3,
    ST_SRC_RD  = 4'd4,
    ST_DST_EXT = 4'd5,
    ST_DST_RD  = 4'd6,
    ST_EXEC    = 4'd7,
    ST_WRITE   = 4'd8,
    ST_PUSH    = 4'd9,
    ST_HALT    = 4'd10
  } seq_state_e;

  // Format I opcodes (IR[15:12]) with special sequencing
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;

  // Format II op field (IR[9:7])
  localparam logic [2:0] F2_RRC  = 3'd0;
  localparam logic [2:0] F2_SWPB = 3'd1;
  localparam logic [2:0] F2_RRA  = 3'd2;
  localparam logic [2:0] F2_SXT  = 3'd3;
  localparam logic [2:0] F2_PUSH = 3'd4;
  localparam logic [2:0] F2_CALL = 3'd5;
  localparam logic [2:0] F2_RETI = 3'd6;

  localparam logic [2:0] JMP_PREFIX  = 3'b001;
  localparam logic [5:0] FMT2_PREFIX = 6'b000100;

  // Source addressing modes (As)
  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;

  // Register indices
  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

endpackage

// File: rtl/msp430_ir_decode.sv
// Combinational instruction classifier for the sequencer.
// Ports:
//   ir            instruction word held in the IR
//   is_jump       conditional/unconditional jump (IR[15:13]=001)
//   is_fmt1       two-operand instruction
//   is_fmt2       single-operand prefix (any op field)
//   fmt2_op       Format II op field
//   need_src_ext  source extension word must be fetched
//   need_src_rd   source operand must be read from memory
//   need_dst_ext  destination extension word must be fetched
//   need_dst_rd   destination operand must be read before EXEC
//   need_wb       instruction produces a result to write back
//   dst_mem       the result goes to memory rather than a register
//   src_inc       source register is post-incremented (As=11)
//   is_illegal    opcode not supported
module msp430_ir_decode
  import msp430_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output logic            is_jump,
  output logic            is_fmt1,
  output logic            is_fmt2,
  output logic [2:0]      fmt2_op,
  output logic            need_src_ext,
  output logic            need_src_rd,
  output logic            need_dst_ext,
  output logic            need_dst_rd,
  output logic            need_wb,
  output logic            dst_mem,
  output logic            src_inc,
  output logic            is_illegal
);

  logic [3:0] opcode;
  logic [3:0] rs;
  logic [1:0] as_mode;
  logic       ad;
  logic       fmt2_ok;
  logic       has_src;
  logic       const_gen;
  logic       immediate;
  logic       unused_bw;

  // Byte/word select does not influence sequencing
  assign unused_bw = ir[6];

  assign opcode  = ir[15:12];
  assign as_mode = ir[5:4];
  assign ad      = ir[7];

  assign is_jump = (ir[15:13] == JMP_PREFIX);
  assign is_fmt1 = (opcode >= OP_MOV);
  assign is_fmt2 = (ir[15:10] == FMT2_PREFIX);
  assign fmt2_op = ir[9:7];

  // RETI and the reserved op are rejected here, not sequenced
  assign fmt2_ok    = is_fmt2 && (fmt2_op <= F2_CALL);
  assign is_illegal = !(is_jump || is_fmt1 || fmt2_ok);
  assign has_src    = is_fmt1 || fmt2_ok;

  // Format II names its single operand in the low nibble
  assign rs = is_fmt2 ? ir[3:0] : ir[11:8];

  // R3 in any mode, and R2 in the indirect modes, synthesise constants
  assign const_gen = (rs == REG_CG) || ((rs == REG_SR) && as_mode[1]);
  assign immediate = (as_mode == AS_INC) && (rs == REG_PC);

  assign need_src_ext = has_src &&
                        (((as_mode == AS_IDX) && (rs != REG_CG)) || immediate);
  assign need_src_rd  = has_src && (as_mode != AS_REG) && !const_gen && !immediate;
  assign src_inc      = (as_mode == AS_INC);

  assign need_dst_ext = is_fmt1 && ad;
  assign need_dst_rd  = need_dst_ext && (opcode != OP_MOV);

  // Only RRC/SWPB/RRA/SXT write a result among the single-operand ops
  assign need_wb = is_fmt1 ? ((opcode != OP_CMP) && (opcode != OP_BIT))
                           : (fmt2_ok && (fmt2_op <= F2_SXT));
  assign dst_mem = is_fmt1 ? ad : (as_mode != AS_REG);

endmodule

// File: rtl/msp430_sequencer.sv
// Instruction control FSM for the MSP430 pipeline: selects the address source
// and issues memory, IR, PC/SP, ALU and writeback strobes per cycle.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   MDB_in        memory data bus, captured into the IR on ir_load
//   mem_ready     current memory access completes this cycle
//   MAB_SEL       address source (PC / SP / CALC)
//   mem_rd/mem_wr memory strobes, held until mem_ready
//   ir_load, pc_inc, pc_load_rst, sp_dec, src_ext_load, dst_ext_load,
//   src_autoinc, alu_en, reg_wr, jmp_take   datapath strobes
//   illegal       one-cycle pulse on an unsupported opcode
//   bus_err       sticky memory timeout flag
//   state         current FSM state (debug)
module msp430_sequencer
  import msp430_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IR_W-1:0]    MDB_in,
  input  logic               mem_ready,
  output logic [MAB_W-1:0]   MAB_SEL,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load_rst,
  output logic               sp_dec,
  output logic               src_ext_load,
  output logic               dst_ext_load,
  output logic               src_autoinc,
  output logic               alu_en,
  output logic               reg_wr,
  output logic               jmp_take,
  output logic               illegal,
  output logic               bus_err,
  output logic [STATE_W-1:0] state
);

  seq_state_e       state_q, state_d, after_src;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IR_W-1:0]  ir_q;
  logic             bus_err_q;
  logic             mem_cyc;
  logic             stall;
  logic             timeout;
  logic             push_call;

  logic       is_jump, is_fmt1, is_fmt2, is_illegal;
  logic [2:0] fmt2_op;
  logic       need_src_ext, need_src_rd, need_dst_ext, need_dst_rd;
  logic       need_wb, dst_mem, src_inc;

  msp430_ir_decode u_decode (
    .ir           (ir_q),
    .is_jump      (is_jump),
    .is_fmt1      (is_fmt1),
    .is_fmt2      (is_fmt2),
    .fmt2_op      (fmt2_op),
    .need_src_ext (need_src_ext),
    .need_src_rd  (need_src_rd),
    .need_dst_ext (need_dst_ext),
    .need_dst_rd  (need_dst_rd),
    .need_wb      (need_wb),
    .dst_mem      (dst_mem),
    .src_inc      (src_inc),
    .is_illegal   (is_illegal)
  );

  assign push_call = is_fmt2 && ((fmt2_op == F2_PUSH) || (fmt2_op == F2_CALL));
  assign bus_err   = bus_err_q;
  assign state     = state_q;

  // State, wait counter, IR and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      wait_cnt_q <= '0;
      ir_q       <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (ir_load) ir_q <= MDB_in;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_d      = state_q;
    MAB_SEL      = MAB_PC;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load_rst  = 1'b0;
    sp_dec       = 1'b0;
    src_ext_load = 1'b0;
    dst_ext_load = 1'b0;
    src_autoinc  = 1'b0;
    alu_en       = 1'b0;
    reg_wr       = 1'b0;
    jmp_take     = 1'b0;
    illegal      = 1'b0;
    mem_cyc      = 1'b0;

    // Where the source phase hands over once its operand is in hand
    after_src = need_dst_ext ? ST_DST_EXT : (push_call ? ST_PUSH : ST_EXEC);

    unique case (state_q)
      ST_RESET: begin
        pc_load_rst = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        mem_cyc = 1'b1;
        mem_rd  = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_jump) begin
          jmp_take = 1'b1;
          state_d  = ST_FETCH;
        end else if (is_illegal || !(is_fmt1 || is_fmt2)) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (need_src_ext) begin
          state_d = ST_SRC_EXT;
        end else if (need_src_rd) begin
          state_d = ST_SRC_RD;
        end else begin
          state_d = after_src;
        end
      end
      ST_SRC_EXT: begin
        mem_cyc = 1'b1;
        mem_rd  = 1'b1;
        if (mem_ready) begin
          src_ext_load = 1'b1;
          pc_inc       = 1'b1;
          state_d      = need_src_rd ? ST_SRC_RD : after_src;
        end
      end
      ST_SRC_RD: begin
        mem_cyc = 1'b1;
        MAB_SEL = MAB_CALC;
        mem_rd  = 1'b1;
        if (mem_ready) begin
          src_autoinc = src_inc;
          state_d     = after_src;
        end
      end
      ST_DST_EXT: begin
        mem_cyc = 1'b1;
        mem_rd  = 1'b1;
        if (mem_ready) begin
          dst_ext_load = 1'b1;
          pc_inc       = 1'b1;
          state_d      = need_dst_rd ? ST_DST_RD : ST_EXEC;
        end
      end
      ST_DST_RD: begin
        mem_cyc = 1'b1;
        MAB_SEL = MAB_CALC;
        mem_rd  = 1'b1;
        if (mem_ready) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_en  = 1'b1;
        reg_wr  = need_wb && !dst_mem;
        state_d = (need_wb && dst_mem) ? ST_WRITE : ST_FETCH;
      end
      ST_WRITE: begin
        mem_cyc = 1'b1;
        MAB_SEL = MAB_CALC;
        mem_wr  = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_PUSH: begin
        mem_cyc = 1'b1;
        MAB_SEL = MAB_SP;
        mem_wr  = 1'b1;
        // A zero wait count marks the first cycle in this state
        sp_dec  = (wait_cnt_q == '0);
        if (mem_ready) begin
          reg_wr  = (fmt2_op == F2_CALL);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase

    stall      = mem_cyc && !mem_ready;
    timeout    = stall && (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
    wait_cnt_d = (stall && !timeout) ? (wait_cnt_q + CNT_W'(1)) : '0;
    if (timeout) state_d = ST_HALT;

    // Reset suppresses every strobe immediately, including a pending write
    if (rst) begin
      MAB_SEL      = MAB_PC;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      ir_load      = 1'b0;
      pc_inc       = 1'b0;
      pc_load_rst  = 1'b0;
      sp_dec       = 1'b0;
      src_ext_load = 1'b0;
      dst_ext_load = 1'b0;
      src_autoinc  = 1'b0;
      alu_en       = 1'b0;
      reg_wr       = 1'b0;
      jmp_take     = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

// File: tb/tb_msp430_sequencer.sv
// Directed bench for msp430_sequencer: walks instructions cycle by cycle and
// compares state, address source and strobe set against hand-derived values.
module tb_msp430_sequencer;

  localparam int unsigned S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_SRC_EXT = 3,
                          S_SRC_RD = 4, S_DST_EXT = 5, S_DST_RD = 6, S_EXEC = 7,
                          S_WRITE = 8, S_PUSH = 9, S_HALT = 10;

  // Strobe bit positions in the packed comparison vector
  localparam logic [12:0] RD  = 13'h1000, WR  = 13'h0800, IRL = 13'h0400,
                          PCI = 13'h0200, PLR = 13'h0100, SPD = 13'h0080,
                          SXL = 13'h0040, DXL = 13'h0020, SAI = 13'h0010,
                          ALU = 13'h0008, RW  = 13'h0004, JT  = 13'h0002,
                          ILL = 13'h0001, NONE = 13'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] MDB_in;
  logic        mem_ready;
  logic [2:0]  MAB_SEL;
  logic        mem_rd, mem_wr, ir_load, pc_inc, pc_load_rst, sp_dec;
  logic        src_ext_load, dst_ext_load, src_autoinc, alu_en, reg_wr;
  logic        jmp_take, illegal, bus_err;
  logic [3:0]  state;
  logic [12:0] strb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  msp430_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .MDB_in       (MDB_in),
    .mem_ready    (mem_ready),
    .MAB_SEL      (MAB_SEL),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load_rst  (pc_load_rst),
    .sp_dec       (sp_dec),
    .src_ext_load (src_ext_load),
    .dst_ext_load (dst_ext_load),
    .src_autoinc  (src_autoinc),
    .alu_en       (alu_en),
    .reg_wr       (reg_wr),
    .jmp_take     (jmp_take),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .state        (state)
  );

  assign strb = {mem_rd, mem_wr, ir_load, pc_inc, pc_load_rst, sp_dec,
                 src_ext_load, dst_ext_load, src_autoinc, alu_en, reg_wr,
                 jmp_take, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Check the current cycle (inputs already driven), then advance one cycle
  task automatic look(input string tag, input int unsigned st, input int unsigned mab,
                      input logic [12:0] s);
    #1;
    chk({tag, ".state"}, 32'(state), st);
    chk({tag, ".mab"},   32'(MAB_SEL), mab);
    chk({tag, ".strb"},  32'(strb), 32'(s));
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    MDB_in    = 16'h4405;
    repeat (2) @(negedge clk);
    chk("rst.bus_err", 32'(bus_err), 0);
    look("rst", S_RESET, 0, NONE);

    // MOV R4,R5
    rst = 1'b0;
    look("mov.reset",  S_RESET,  0, PLR);
    look("mov.fetch",  S_FETCH,  0, RD | IRL | PCI);
    look("mov.decode", S_DECODE, 0, NONE);
    look("mov.exec",   S_EXEC,   0, ALU | RW);

    // ADD 2(R4),4(R5)
    MDB_in = 16'h5495;
    look("add.fetch",  S_FETCH,   0, RD | IRL | PCI);
    look("add.decode", S_DECODE,  0, NONE);
    look("add.sext",   S_SRC_EXT, 0, RD | SXL | PCI);
    look("add.srd",    S_SRC_RD,  2, RD);
    look("add.dext",   S_DST_EXT, 0, RD | DXL | PCI);
    look("add.drd",    S_DST_RD,  2, RD);
    look("add.exec",   S_EXEC,    0, ALU);
    look("add.write",  S_WRITE,   2, WR);

    // CMP #2,R5 via constant generator
    MDB_in = 16'h9325;
    look("cmp.fetch",  S_FETCH,  0, RD | IRL | PCI);
    look("cmp.decode", S_DECODE, 0, NONE);
    look("cmp.exec",   S_EXEC,   0, ALU);

    // PUSH R4 with three stall cycles
    MDB_in = 16'h1204;
    look("push.fetch",  S_FETCH,  0, RD | IRL | PCI);
    mem_ready = 1'b0;
    look("push.decode", S_DECODE, 0, NONE);
    look("push.w0",     S_PUSH,   1, WR | SPD);
    look("push.w1",     S_PUSH,   1, WR);
    look("push.w2",     S_PUSH,   1, WR);
    mem_ready = 1'b1;
    look("push.done",   S_PUSH,   1, WR);

    // RETI is rejected
    MDB_in = 16'h1300;
    look("reti.fetch",  S_FETCH,  0, RD | IRL | PCI);
    look("reti.decode", S_DECODE, 0, ILL);

    // JMP pulses jmp_take in DECODE
    MDB_in = 16'h3C00;
    look("jmp.fetch",  S_FETCH,  0, RD | IRL | PCI);
    look("jmp.decode", S_DECODE, 0, JT);

    // MOV @R5+,R6: source read with post-increment
    MDB_in = 16'h4536;
    look("inc.fetch",  S_FETCH,  0, RD | IRL | PCI);
    look("inc.decode", S_DECODE, 0, NONE);
    look("inc.srd",    S_SRC_RD, 2, RD | SAI);
    look("inc.exec",   S_EXEC,   0, ALU | RW);

    // CALL #imm: extension word, then push with PC load on completion
    MDB_in = 16'h12B0;
    look("call.fetch",  S_FETCH,   0, RD | IRL | PCI);
    look("call.decode", S_DECODE,  0, NONE);
    look("call.sext",   S_SRC_EXT, 0, RD | SXL | PCI);
    look("call.push",   S_PUSH,    1, WR | SPD | RW);

    // Reset while a write is stalled
    MDB_in = 16'h5495;
    look("rw.fetch",  S_FETCH,   0, RD | IRL | PCI);
    look("rw.decode", S_DECODE,  0, NONE);
    look("rw.sext",   S_SRC_EXT, 0, RD | SXL | PCI);
    look("rw.srd",    S_SRC_RD,  2, RD);
    look("rw.dext",   S_DST_EXT, 0, RD | DXL | PCI);
    look("rw.drd",    S_DST_RD,  2, RD);
    look("rw.exec",   S_EXEC,    0, ALU);
    mem_ready = 1'b0;
    look("rw.write",  S_WRITE,   2, WR);
    rst = 1'b1;
    look("rw.rst",    S_WRITE,   0, NONE);
    look("rw.after",  S_RESET,   0, NONE);
    rst = 1'b0;
    mem_ready = 1'b1;
    look("rw.reset",  S_RESET,   0, PLR);

    // Fetch stalls until the timeout raises bus_err and halts
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to.bus_err_low", 32'(bus_err), 0);
      look("to.fetch", S_FETCH, 0, RD);
    end
    chk("to.bus_err", 32'(bus_err), 1);
    look("to.halt0", S_HALT, 0, NONE);
    mem_ready = 1'b1;
    look("to.halt1", S_HALT, 0, NONE);
    chk("to.sticky", 32'(bus_err), 1);
    rst = 1'b1;
    look("to.rst", S_HALT, 0, NONE);
    chk("to.cleared", 32'(bus_err), 0);
    rst = 1'b0;
    look("to.reset", S_RESET, 0, PLR);
    look("to.fetch_again", S_FETCH, 0, RD | IRL | PCI);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
